// File: rtl/occupancy_hist_pkg.sv
// Shared register map, control bit positions and sizing helper for the
// multi-channel FIFO occupancy histogram.
package occupancy_hist_pkg;

    // Word indices (byte address bits [6:2])
    localparam logic [4:0] REG_CTRL   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd1;
    localparam logic [4:0] REG_SEL    = 5'd2;
    localparam logic [4:0] REG_CYCLES = 5'd3;
    localparam logic [4:0] REG_BIN0   = 5'd4;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_CLEAR    = 1;
    localparam int CTRL_SNAP     = 2;
    localparam int CTRL_STOP_SAT = 3;

    localparam int STATUS_SAT_BASE = 16;

    function automatic int num_bins(input int step_bits);
        return 1 << step_bits;
    endfunction

endpackage

// File: rtl/occ_hist_channel.sv
// One monitored FIFO: arming, live occupancy bins, trailing-idle counter,
// sticky saturation flag and the snapshot bank read back by the host.
module occ_hist_channel
    import occupancy_hist_pkg::*;
#(
    parameter int COUNTER_WIDTH       = 6,
    parameter int HISTOGRAM_STEP_BITS = 2,
    parameter int BIN_WIDTH           = 32,
    parameter int NUM_BINS            = num_bins(HISTOGRAM_STEP_BITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          srst,
    input  logic                          run,
    input  logic                          stop_on_sat,
    input  logic                          snapshot,
    input  logic [COUNTER_WIDTH-1:0]      data_count,
    output logic                          sat,
    output logic [NUM_BINS*BIN_WIDTH-1:0] snap_bins
);

    localparam logic [BIN_WIDTH-1:0] BIN_MAX = {BIN_WIDTH{1'b1}};
    localparam logic [BIN_WIDTH-1:0] BIN_ONE = {{(BIN_WIDTH-1){1'b0}}, 1'b1};

    logic                           armed_r;
    logic                           sat_r;
    logic [BIN_WIDTH-1:0]           idle_r;
    logic [BIN_WIDTH-1:0]           bins_r [NUM_BINS];
    logic [BIN_WIDTH-1:0]           snap_r [NUM_BINS];
    logic                           nonzero_s;
    logic                           count_en_s;
    logic [HISTOGRAM_STEP_BITS-1:0] bin_idx_s;

    // The arming sample itself is counted, hence the OR with nonzero_s
    assign nonzero_s  = (data_count != {COUNTER_WIDTH{1'b0}});
    assign bin_idx_s  = data_count[COUNTER_WIDTH-1 -: HISTOGRAM_STEP_BITS];
    assign count_en_s = run & (armed_r | nonzero_s) & ~(stop_on_sat & sat_r);

    // Arming, sticky saturation and consecutive-idle tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 1'b0;
            sat_r   <= 1'b0;
            idle_r  <= {BIN_WIDTH{1'b0}};
        end else if (srst) begin
            armed_r <= 1'b0;
            sat_r   <= 1'b0;
            idle_r  <= {BIN_WIDTH{1'b0}};
        end else begin
            if (run && nonzero_s) begin
                armed_r <= 1'b1;
            end
            if (count_en_s && (bins_r[bin_idx_s] >= (BIN_MAX - BIN_ONE))) begin
                sat_r <= 1'b1;
            end
            if (nonzero_s) begin
                idle_r <= {BIN_WIDTH{1'b0}};
            end else if (count_en_s && (idle_r != BIN_MAX)) begin
                idle_r <= idle_r + BIN_ONE;
            end
        end
    end

    // Live bins and snapshot bank; idle <= bin0 so the subtraction cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                bins_r[k] <= {BIN_WIDTH{1'b0}};
                snap_r[k] <= {BIN_WIDTH{1'b0}};
            end
        end else if (srst) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                bins_r[k] <= {BIN_WIDTH{1'b0}};
                snap_r[k] <= {BIN_WIDTH{1'b0}};
            end
        end else begin
            if (count_en_s && (bins_r[bin_idx_s] != BIN_MAX)) begin
                bins_r[bin_idx_s] <= bins_r[bin_idx_s] + BIN_ONE;
            end
            if (snapshot) begin
                snap_r[0] <= bins_r[0] - idle_r;
                for (int k = 1; k < NUM_BINS; k++) begin
                    snap_r[k] <= bins_r[k];
                end
            end
        end
    end

    assign sat = sat_r;

    for (genvar k = 0; k < NUM_BINS; k++) begin : g_flat
        assign snap_bins[k*BIN_WIDTH +: BIN_WIDTH] = snap_r[k];
    end

endmodule

// File: rtl/multi_occupancy_histogram.sv
// AXI4-Lite readable occupancy histogram over NUM_CHANNELS FIFO data_count
// buses, with run/stop, atomic snapshot and clear of all channels.
module multi_occupancy_histogram
    import occupancy_hist_pkg::*;
#(
    parameter int NUM_CHANNELS        = 4,
    parameter int COUNTER_WIDTH       = 6,
    parameter int HISTOGRAM_STEP_BITS = 2,
    parameter int C_S_AXI_DATA_WIDTH  = 32,
    parameter int C_S_AXI_ADDR_WIDTH  = 7,
    parameter int BIN_WIDTH           = 32
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] data_count,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int NUM_BINS = num_bins(HISTOGRAM_STEP_BITS);

    logic                          awready_r, bvalid_r, arready_r, rvalid_r;
    logic [31:0]                   rdata_r;
    logic                          run_r, stop_sat_r, clear_r, snap_req_r;
    logic [3:0]                    sel_r;
    logic [31:0]                   cycles_r, cycles_snap_r;
    logic                          wr_en_s, rd_en_s;
    logic [4:0]                    wr_word_s, rd_word_s;
    logic [31:0]                   rd_mux_s;
    logic [NUM_BINS*BIN_WIDTH-1:0] sel_bins_s;
    logic [NUM_BINS*BIN_WIDTH-1:0] snap_flat_s [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]       sat_s;
    logic                          unused_s;

    assign wr_en_s   = awready_r & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en_s   = arready_r & S_AXI_ARVALID;
    assign wr_word_s = S_AXI_AWADDR[6:2];
    assign rd_word_s = S_AXI_ARADDR[6:2];
    assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[1:0], S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:4]};

    // Write acceptance; a pending BVALID blocks the next write
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
        end else begin
            awready_r <= ~awready_r & ~bvalid_r & S_AXI_AWVALID & S_AXI_WVALID;
            if (wr_en_s) begin
                bvalid_r <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Control and select registers; clear/snapshot become one-cycle strobes
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            run_r      <= 1'b0;
            stop_sat_r <= 1'b0;
            clear_r    <= 1'b0;
            snap_req_r <= 1'b0;
            sel_r      <= 4'd0;
        end else begin
            clear_r    <= 1'b0;
            snap_req_r <= 1'b0;
            if (wr_en_s && (wr_word_s == REG_CTRL)) begin
                run_r      <= S_AXI_WDATA[CTRL_RUN];
                stop_sat_r <= S_AXI_WDATA[CTRL_STOP_SAT];
                clear_r    <= S_AXI_WDATA[CTRL_CLEAR];
                snap_req_r <= S_AXI_WDATA[CTRL_SNAP];
            end
            if (wr_en_s && (wr_word_s == REG_SEL)) begin
                sel_r <= S_AXI_WDATA[3:0];
            end
        end
    end

    // Saturating run-time cycle counter and its snapshot
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cycles_r      <= 32'd0;
            cycles_snap_r <= 32'd0;
        end else if (clear_r) begin
            cycles_r      <= 32'd0;
            cycles_snap_r <= 32'd0;
        end else begin
            if (run_r && (cycles_r != 32'hFFFF_FFFF)) begin
                cycles_r <= cycles_r + 32'd1;
            end
            if (snap_req_r) begin
                cycles_snap_r <= cycles_r;
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        occ_hist_channel #(
            .COUNTER_WIDTH       (COUNTER_WIDTH),
            .HISTOGRAM_STEP_BITS (HISTOGRAM_STEP_BITS),
            .BIN_WIDTH           (BIN_WIDTH),
            .NUM_BINS            (NUM_BINS)
        ) u_chan (
            .clk         (S_AXI_ACLK),
            .rst_n       (S_AXI_ARESETN),
            .srst        (clear_r),
            .run         (run_r),
            .stop_on_sat (stop_sat_r),
            .snapshot    (snap_req_r),
            .data_count  (data_count[c*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .sat         (sat_s[c]),
            .snap_bins   (snap_flat_s[c])
        );
    end

    // Read data selection; SEL beyond NUM_CHANNELS leaves the bins at zero
    always_comb begin
        rd_mux_s   = 32'd0;
        sel_bins_s = {(NUM_BINS*BIN_WIDTH){1'b0}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sel_bins_s = (sel_r == 4'(c)) ? snap_flat_s[c] : sel_bins_s;
        end
        case (rd_word_s)
            REG_CTRL: begin
                rd_mux_s[CTRL_RUN]      = run_r;
                rd_mux_s[CTRL_STOP_SAT] = stop_sat_r;
            end
            REG_STATUS: begin
                rd_mux_s[0]                                = run_r;
                rd_mux_s[STATUS_SAT_BASE +: NUM_CHANNELS] = sat_s;
            end
            REG_SEL:    rd_mux_s[3:0] = sel_r;
            REG_CYCLES: rd_mux_s      = cycles_snap_r;
            default: begin
                for (int k = 0; k < NUM_BINS; k++) begin
                    rd_mux_s[BIN_WIDTH-1:0] = (rd_word_s == (REG_BIN0 + 5'(k))) ?
                        sel_bins_s[k*BIN_WIDTH +: BIN_WIDTH] : rd_mux_s[BIN_WIDTH-1:0];
                end
            end
        endcase
    end

    // Read acceptance and registered response
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            arready_r <= ~arready_r & ~rvalid_r & S_AXI_ARVALID;
            if (rd_en_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_mux_s;
            end else if (S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = awready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_multi_occupancy_histogram.sv
// Directed bench: a full-width instance and a 5-bit-bin instance share all
// inputs so saturation can be reached in a few dozen cycles.
module tb_multi_occupancy_histogram;

    localparam int NCH = 4;
    localparam int CW  = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH*CW-1:0] data_count;
    logic [6:0]     awaddr, araddr;
    logic [2:0]     awprot, arprot;
    logic           awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;

    logic           awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
    logic [1:0]     bresp_a, rresp_a;
    logic [31:0]    rdata_a;
    logic           awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
    logic [1:0]     bresp_b, rresp_b;
    logic [31:0]    rdata_b;

    logic           use_b;
    logic           awready, wready, bvalid, arready, rvalid;
    logic [1:0]     bresp, rresp;
    logic [31:0]    rdata;

    int errors = 0;
    int checks = 0;

    assign awready = use_b ? awready_b : awready_a;
    assign wready  = use_b ? wready_b  : wready_a;
    assign bvalid  = use_b ? bvalid_b  : bvalid_a;
    assign bresp   = use_b ? bresp_b   : bresp_a;
    assign arready = use_b ? arready_b : arready_a;
    assign rvalid  = use_b ? rvalid_b  : rvalid_a;
    assign rresp   = use_b ? rresp_b   : rresp_a;
    assign rdata   = use_b ? rdata_b   : rdata_a;

    always #5 clk = ~clk;

    multi_occupancy_histogram #(.NUM_CHANNELS(NCH), .COUNTER_WIDTH(CW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .data_count(data_count),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready_a), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_a), .S_AXI_BRESP(bresp_a),
        .S_AXI_BVALID(bvalid_a), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_a),
        .S_AXI_RDATA(rdata_a), .S_AXI_RRESP(rresp_a), .S_AXI_RVALID(rvalid_a),
        .S_AXI_RREADY(rready)
    );

    multi_occupancy_histogram #(.NUM_CHANNELS(NCH), .COUNTER_WIDTH(CW), .BIN_WIDTH(5)) dut_sat (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .data_count(data_count),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready_b), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_b), .S_AXI_BRESP(bresp_b),
        .S_AXI_BVALID(bvalid_b), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_b),
        .S_AXI_RDATA(rdata_b), .S_AXI_RRESP(rresp_b), .S_AXI_RVALID(rvalid_b),
        .S_AXI_RREADY(rready)
    );

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 16) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 16) begin @(negedge clk); n++; end
        resp = bresp;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL write_timeout addr=%h: bvalid=%b expected 1", addr, bvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [6:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 16) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 16) begin @(negedge clk); n++; end
        data = rdata; resp = rresp;
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL read_timeout addr=%h: rvalid=%b expected 1", addr, rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic drive_ch(input int ch, input logic [5:0] val, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            data_count[ch*CW +: CW] = val;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r;
        logic [6:0]  addrs [4] = '{7'h00, 7'h04, 7'h0C, 7'h10};
        repeat (3) @(negedge clk);
        checks++;
        if ({awready_a, wready_a, bvalid_a, arready_a, rvalid_a, bresp_a, rresp_a, rdata_a} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {awready_a, wready_a, bvalid_a, arready_a, rvalid_a, bresp_a, rresp_a, rdata_a});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], d, r);
            checks++;
            if (d !== 32'd0 || r !== 2'b00) begin
                errors++;
                $display("FAIL reset_read addr=%h: got %h/%b expected 0/00", addrs[i], d, r);
            end
        end
        axi_write(7'h08, 32'd0, r);
        checks++;
        if (r !== 2'b00) begin
            errors++;
            $display("FAIL reset_bresp: got %b expected 00", r);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [1:0] r;
        logic [6:0]  addrs [4] = '{7'h10, 7'h14, 7'h18, 7'h1C};
        logic [31:0] exp   [4] = '{32'd0, 32'd5, 32'd0, 32'd3};
        axi_write(7'h00, 32'h1, r);
        drive_ch(0, 6'h00, 10);
        drive_ch(0, 6'h10, 5);
        drive_ch(0, 6'h30, 3);
        drive_ch(0, 6'h00, 4);
        axi_write(7'h00, 32'h5, r);
        axi_write(7'h08, 32'd0, r);
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], d, r);
            checks++;
            if (d !== exp[i]) begin
                errors++;
                $display("FAIL basic_bin addr=%h: got %0d expected %0d", addrs[i], d, exp[i]);
            end
        end
        axi_read(7'h0C, d, r);
        checks++;
        if (d < 32'd22) begin
            errors++;
            $display("FAIL basic_cycles: got %0d expected >= 22", d);
        end
    endtask

    task automatic test_two_channel();
        logic [31:0] d; logic [1:0] r;
        axi_write(7'h00, 32'h3, r);
        drive_ch(1, 6'h3F, 20);
        drive_ch(1, 6'h00, 1);
        axi_write(7'h00, 32'h5, r);
        axi_write(7'h08, 32'd1, r);
        axi_read(7'h1C, d, r);
        checks++;
        if (d !== 32'd20) begin
            errors++;
            $display("FAIL ch1_bin3: got %0d expected 20", d);
        end
        axi_read(7'h10, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL ch1_bin0: got %0d expected 0", d);
        end
        axi_write(7'h08, 32'd0, r);
        for (int k = 0; k < 4; k++) begin
            axi_read(7'h10 + 7'(4*k), d, r);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL ch0_unarmed_bin%0d: got %0d expected 0", k, d);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] d; logic [1:0] r;
        logic [6:0]  addrs  [4] = '{7'h10, 7'h14, 7'h18, 7'h1C};
        // narrow build saturates bin2 at 31 and then stops; full build keeps counting
        logic [31:0] exp_b  [4] = '{32'd0, 32'd0, 32'h1F, 32'd0};
        logic [31:0] exp_a  [4] = '{32'd0, 32'd5, 32'd40, 32'd5};
        axi_write(7'h00, 32'hB, r);
        drive_ch(2, 6'h20, 40);
        drive_ch(2, 6'h10, 5);
        drive_ch(2, 6'h30, 5);
        drive_ch(2, 6'h00, 1);
        axi_write(7'h00, 32'hD, r);
        axi_write(7'h08, 32'd2, r);
        for (int i = 0; i < 4; i++) begin
            use_b = 1'b1;
            axi_read(addrs[i], d, r);
            checks++;
            if (d !== exp_b[i]) begin
                errors++;
                $display("FAIL sat_narrow_bin addr=%h: got %h expected %h", addrs[i], d, exp_b[i]);
            end
            use_b = 1'b0;
            axi_read(addrs[i], d, r);
            checks++;
            if (d !== exp_a[i]) begin
                errors++;
                $display("FAIL sat_wide_bin addr=%h: got %0d expected %0d", addrs[i], d, exp_a[i]);
            end
        end
        use_b = 1'b1;
        axi_read(7'h04, d, r);
        use_b = 1'b0;
        checks++;
        if (d !== 32'h0004_0001) begin
            errors++;
            $display("FAIL sat_status_narrow: got %h expected 00040001", d);
        end
        axi_read(7'h04, d, r);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++;
            $display("FAIL sat_status_wide: got %h expected 00000001", d);
        end
    endtask

    task automatic test_clear_snapshot();
        logic [31:0] d; logic [1:0] r;
        axi_write(7'h00, 32'h7, r);
        use_b = 1'b1;
        axi_read(7'h18, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL clear_bin2: got %h expected 0", d);
        end
        axi_read(7'h04, d, r);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++;
            $display("FAIL clear_status: got %h expected 00000001", d);
        end
        use_b = 1'b0;
        axi_read(7'h0C, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL clear_cycles: got %0d expected 0", d);
        end
        drive_ch(2, 6'h20, 3);
        drive_ch(2, 6'h00, 1);
        axi_write(7'h00, 32'h5, r);
        axi_read(7'h18, d, r);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL resume_bin2: got %0d expected 3", d);
        end
        axi_read(7'h0C, d, r);
        checks++;
        if (d == 32'd0) begin
            errors++;
            $display("FAIL resume_cycles: got %0d expected nonzero", d);
        end
    endtask

    task automatic test_unmapped_sel();
        logic [31:0] d; logic [1:0] r;
        axi_write(7'h08, 32'd9, r);
        axi_read(7'h08, d, r);
        checks++;
        if (d !== 32'd9) begin
            errors++;
            $display("FAIL sel_readback: got %0d expected 9", d);
        end
        axi_read(7'h18, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL sel9_bin2: got %0d expected 0", d);
        end
        axi_write(7'h7C, 32'hFFFF_FFFF, r);
        axi_read(7'h7C, d, r);
        checks++;
        if (d !== 32'd0 || r !== 2'b00) begin
            errors++;
            $display("FAIL unmapped_read: got %h/%b expected 0/00", d, r);
        end
        axi_read(7'h00, d, r);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL ctrl_after_unmapped: got %h expected 1", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r;
        int n;
        @(negedge clk);
        bready = 1'b0;
        awaddr = 7'h08; wdata = 32'd1; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 16) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        wdata = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                errors++;
                $display("FAIL bready_hold cyc%0d: bvalid=%b awready=%b expected 1/0", i, bvalid, awready);
            end
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL bvalid_release: got %b expected 0", bvalid);
        end
        axi_read(7'h08, d, r);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL second_write_blocked: SEL got %0d expected 1", d);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic [1:0] r;
        int n;
        @(negedge clk);
        awaddr = 7'h08; wdata = 32'd5; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 16) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({awready_a, wready_a, bvalid_a} !== 3'b000) begin
            errors++;
            $display("FAIL abort_outputs: got %b expected 000", {awready_a, wready_a, bvalid_a});
        end
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        axi_read(7'h08, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL abort_sel: got %0d expected 0", d);
        end
        axi_read(7'h00, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL abort_ctrl: got %h expected 0", d);
        end
    endtask

    initial begin
        rst_n = 1'b0; data_count = '0; use_b = 1'b0;
        awaddr = 7'd0; araddr = 7'd0; awprot = 3'd0; arprot = 3'd0; wstrb = 4'hF;
        wdata = 32'd0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        test_reset();
        test_basic();
        test_two_channel();
        test_saturation();
        test_clear_snapshot();
        test_unmapped_sel();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
